// File: rtl/alu_dispatch_pkg.sv
// Shared ALU op codes, RV32I opcodes and the issued-command bundle.
// Imported by alu_decode and alu_dispatch.
package alu_dispatch_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    typedef struct packed {
        logic [3:0]      sel;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } alu_cmd_t;

    localparam alu_cmd_t CMD_RESET = '{sel: ALU_ADD, default: '0};

    // alt picks SUB over ADD and SRA over SRL; ignored elsewhere
    function automatic logic [3:0] f3_to_sel(input logic [2:0] f3,
                                             input logic alt);
        logic [3:0] s;
        unique case (f3)
            3'b000:  s = alt ? ALU_SUB : ALU_ADD;
            3'b001:  s = ALU_SLL;
            3'b010:  s = ALU_SLT;
            3'b011:  s = ALU_SLTU;
            3'b100:  s = ALU_XOR;
            3'b101:  s = alt ? ALU_SRA : ALU_SRL;
            3'b110:  s = ALU_OR;
            default: s = ALU_AND;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode into an ALU command (sel, a, b, rd).
// Unhandled or malformed encodings come out as illegal ADD 0,0.
module alu_decode
    import alu_dispatch_pkg::*;
(
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output alu_cmd_t        cmd
);

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [3:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            legal;
    logic            is_shift;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u    = {inst[31:12], 12'b0};
    assign shamt    = {{(XLEN-5){1'b0}}, inst[24:20]};
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        sel   = ALU_ADD;
        a     = '0;
        b     = '0;
        legal = 1'b1;
        unique case (1'b1)
            opcode == OPC_OP: begin
                a     = rs1;
                b     = rs2;
                sel   = f3_to_sel(funct3, funct7[5]);
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            opcode == OPC_OP_IMM: begin
                a   = rs1;
                b   = is_shift ? shamt : imm_i;
                // bit 30 is part of the immediate except on right shifts
                sel = f3_to_sel(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
            opcode == OPC_LUI: begin
                sel = ALU_PASSB;
                b   = imm_u;
            end
            opcode == OPC_AUIPC: begin
                a = pc;
                b = imm_u;
            end
            (opcode == OPC_JAL) || (opcode == OPC_JALR): begin
                a = pc;
                b = XLEN'(4);
            end
            default: legal = 1'b0;
        endcase

        cmd.sel     = legal ? sel : ALU_ADD;
        cmd.a       = legal ? a : '0;
        cmd.b       = legal ? b : '0;
        cmd.rd      = inst[11:7];
        cmd.rd_we   = legal && (inst[11:7] != 5'd0);
        cmd.illegal = !legal;
    end

endmodule

// File: rtl/alu_dispatch.sv
// Decode/issue stage: alu_decode behind a 2-entry skid buffer.
// Define ALU_DISPATCH_STATS_EN to add issued/illegal transfer counters.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [DATAW-1:0] pc,
    input  logic [DATAW-1:0] rs1_data,
    input  logic [DATAW-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_sel,
    output logic [DATAW-1:0] alu_a,
    output logic [DATAW-1:0] alu_b,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic             illegal
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_illegal
`endif
);

    alu_cmd_t    dec;
    alu_cmd_t    main_q;
    alu_cmd_t    skid_q;
    skid_state_e state;
    logic        accept;
    logic        drain;

    alu_decode u_decode (
        .inst (inst),
        .pc   (pc),
        .rs1  (rs1_data),
        .rs2  (rs2_data),
        .cmd  (dec)
    );

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_q    <= CMD_RESET;
            skid_q    <= CMD_RESET;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q    <= dec;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_q   <= dec;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        main_q <= dec;
                    end else if (drain) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_q   <= skid_q;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign alu_sel = main_q.sel;
    assign alu_a   = main_q.a;
    assign alu_b   = main_q.b;
    assign rd      = main_q.rd;
    assign rd_we   = main_q.rd_we;
    assign illegal = main_q.illegal;

`ifdef ALU_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else if (drain) begin
            stat_issued <= stat_issued + 32'd1;
            if (main_q.illegal)
                stat_illegal <= stat_illegal + 32'd1;
        end
    end
`endif

endmodule
